hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/hazard_scoreboard.sv | 74 +++++++
 tb/tb_hazard_scoreboard.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared core types for the decode hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd_addr;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tracks in-flight destinations and stalls decode on RAW hazards
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_rd_wren_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    output logic                  stall_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    sb_entry_t               entries [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0]   rs1_hit;
    logic [PIPE_DEPTH-1:0]   rs2_hit;
    logic                    rs1_hazard;
    logic                    rs2_hazard;
    logic                    issue;
    logic [NUM_REGS-1:0]     busy;
    logic [CNT_W-1:0]        stall_cnt;

    // WB entry is still compared: the register file only commits at the end of WB
    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_cmp
        assign rs1_hit[g] = entries[g].valid && (entries[g].rd_addr == id_rs1_addr_i);
        assign rs2_hit[g] = entries[g].valid && (entries[g].rd_addr == id_rs2_addr_i);
    end

    assign rs1_hazard = id_rs1_used_i && (id_rs1_addr_i != '0) && (|rs1_hit);
    assign rs2_hazard = id_rs2_used_i && (id_rs2_addr_i != '0) && (|rs2_hit);
    assign stall_o    = id_valid_i && !flush_i && (rs1_hazard || rs2_hazard);
    assign issue      = id_valid_i && !flush_i && !stall_o && id_rd_wren_i && (id_rd_addr_i != '0);

    always_comb begin
        busy = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (entries[i].valid) begin
                busy[entries[i].rd_addr] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign busy_o      = busy;
    assign stall_cnt_o = stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                entries[i] <= '0;
            end
            stall_cnt <= '0;
        end else if (!hold_i) begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
            entries[0] <= issue ? sb_entry_t'{valid: 1'b1, rd_addr: id_rd_addr_i} : '0;
            if (stall_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized bench against a per-instruction lifetime model
module tb_hazard_scoreboard;

    localparam int PIPE_DEPTH = 3;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, hold, flush, id_valid;
    logic [4:0]       rs1, rs2, rd;
    logic             rs1_used, rs2_used, rd_wren;
    logic             stall;
    logic [31:0]      busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // each issued instruction lives for PIPE_DEPTH non-held edges
    int q_rd[$];
    int q_rem[$];
    int m_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .flush_i(flush),
        .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs1_used_i(rs1_used),
        .id_rs2_addr_i(rs2), .id_rs2_used_i(rs2_used), .id_rd_wren_i(rd_wren),
        .id_rd_addr_i(rd), .stall_o(stall), .busy_o(busy), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic f, input logic v,
                        input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                        input logic u2, input logic w, input logic [4:0] d);
        logic        haz, exp_stall, do_issue;
        logic [31:0] exp_busy;
        @(negedge clk);
        rst_n = r; hold = h; flush = f; id_valid = v;
        rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; rd_wren = w; rd = d;
        #1;
        haz = 1'b0;
        exp_busy = '0;
        foreach (q_rd[k]) begin
            exp_busy[q_rd[k]] = 1'b1;
            if ((u1 && a1 != 0 && q_rd[k] == int'(a1)) || (u2 && a2 != 0 && q_rd[k] == int'(a2)))
                haz = 1'b1;
        end
        exp_stall = v && !f && haz;
        do_issue  = v && !f && !exp_stall && w && (d != 0);
        check("stall", {31'b0, stall}, {31'b0, exp_stall});
        check("busy", busy, exp_busy);
        check("stall_cnt", {28'b0, stall_cnt}, m_cnt);
        @(posedge clk);
        if (!r) begin
            q_rd.delete(); q_rem.delete(); m_cnt = 0;
        end else if (!h) begin
            for (int k = q_rd.size() - 1; k >= 0; k--) begin
                q_rem[k]--;
                if (q_rem[k] == 0) begin
                    q_rd.delete(k); q_rem.delete(k);
                end
            end
            if (do_issue) begin
                q_rd.push_back(int'(d)); q_rem.push_back(PIPE_DEPTH);
            end
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic do_reset();
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_rd(input logic [4:0] d);
        step(1, 0, 0, 1, 0, 0, 0, 0, 1, d);
    endtask

    task automatic read_rs(input logic [4:0] a1, input logic [4:0] a2, input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, a1, a1 != 0, a2, a2 != 0, 0, 0);
    endtask

    initial begin
        m_cnt = 0;
        rst_n = 0; hold = 0; flush = 0; id_valid = 0;
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0; rd_wren = 0;
        do_reset();
        do_reset();

        // single-cycle RAW on x5: three stall cycles then free
        issue_rd(5);
        read_rs(5, 0, 4);
        check("raw_x5_cnt", {28'b0, stall_cnt}, 32'd3);

        // x0 never tracked, never stalls
        do_reset();
        issue_rd(0);
        read_rs(0, 0, 3);
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);

        // x7 two instructions ahead: only WB overlap remains
        issue_rd(7);
        issue_rd(1);
        issue_rd(2);
        read_rs(0, 7, 2);

        // hold mid-stall on x9
        do_reset();
        issue_rd(9);
        read_rs(9, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 9, 1, 0, 0, 0, 0);
        check("hold_cnt", {28'b0, stall_cnt}, 32'd1);
        read_rs(9, 0, 3);

        // flush masks a hazard and creates nothing; reset drops three live entries
        issue_rd(4);
        step(1, 0, 1, 1, 4, 1, 0, 0, 1, 6);
        issue_rd(10);
        issue_rd(11);
        issue_rd(12);
        do_reset();
        read_rs(10, 11, 1);

        // saturation: 21 stall cycles into a 4-bit counter
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue_rd(5'(i + 3));
            read_rs(5'(i + 3), 0, 3);
        end
        check("cnt_sat", {28'b0, stall_cnt}, CNT_MAX);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
                 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 1'($urandom), 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
